// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// Module   : vga_timing_gen_if
// Brief    : Pixel-enable input plus sync/DE/coordinate/pattern outputs.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface vga_timing_gen_if;
  logic        CE;
  logic        Hsync;
  logic        Vsync;
  logic        DE;
  logic [10:0] x;
  logic [10:0] y;
  logic        frame_start;
  logic        line_start;
  logic [15:0] pattern;

  modport master (
    input  CE,
    output Hsync, Vsync, DE, x, y, frame_start, line_start, pattern
  );

  modport slave (
    output CE,
    input  Hsync, Vsync, DE, x, y, frame_start, line_start, pattern
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// Module   : vga_timing_gen
// Brief    : VGA Hsync/Vsync/DE and pixel-coordinate generator; colour-bar
//            test pattern enabled by macro VGA_TIMING_PATTERN_EN.
// Revision : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  wire logic         CLK,
  input  wire logic         RESET,
  vga_timing_gen_if.master  bus
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_HA       = 11'(H_ACTIVE);
  localparam logic [10:0] c_HFP      = 11'(H_FP);
  localparam logic [10:0] c_HSW      = 11'(H_SYNC);
  localparam logic [10:0] c_HBP      = 11'(H_BP);
  localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_VA       = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] c_V_LAST   = 11'(c_V_TOTAL - 1);

  generate
    if (c_H_TOTAL > 2047 || c_V_TOTAL > 2047) begin : g_total_check
      $error("vga_timing_gen: H or V total exceeds 11-bit range");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_len_check
      $error("vga_timing_gen: every timing segment must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_ACT  = 2'd0,
    S_FP   = 2'd1,
    S_SYNC = 2'd2,
    S_BP   = 2'd3
  } hphase_t;

  hphase_t     r_hphase;
  hphase_t     w_hphase_nxt;
  logic [10:0] r_hcnt;
  logic [10:0] w_hcnt_nxt;
  logic [10:0] w_phase_len;

  logic [10:0] r_hn;
  logic [10:0] r_vn;
  logic        r_run;

  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_fs;
  logic        r_ls;

  logic        w_de;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_ls;
  logic        w_fs;

  // Horizontal phase FSM: the phase counter restarts at every phase boundary,
  // so phase base + r_hcnt always equals r_hn.
  always_comb begin
    w_hphase_nxt = r_hphase;
    w_hcnt_nxt   = r_hcnt + 11'd1;
    w_phase_len  = c_HA;
    case (r_hphase)
      S_ACT:  w_phase_len = c_HA;
      S_FP:   w_phase_len = c_HFP;
      S_SYNC: w_phase_len = c_HSW;
      S_BP:   w_phase_len = c_HBP;
    endcase
    if (r_hcnt == w_phase_len - 11'd1) begin
      w_hcnt_nxt = '0;
      case (r_hphase)
        S_ACT:  w_hphase_nxt = S_FP;
        S_FP:   w_hphase_nxt = S_SYNC;
        S_SYNC: w_hphase_nxt = S_BP;
        S_BP:   w_hphase_nxt = S_ACT;
      endcase
    end
  end

  // Until the first step the counters sit at the origin, so the first issued
  // position is always a frame and line start.
  always_comb begin
    w_de    = (r_hn < c_HA) && (r_vn < c_VA);
    w_hsync = !((r_hn >= c_HS_START) && (r_hn < c_HS_END));
    w_vsync = !((r_vn >= c_VS_START) && (r_vn < c_VS_END));
    w_ls    = !r_run || (r_hn == 11'd0);
    w_fs    = !r_run || ((r_hn == 11'd0) && (r_vn == 11'd0));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hphase <= S_ACT;
      r_hcnt   <= '0;
      r_hn     <= '0;
      r_vn     <= '0;
      r_run    <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_de     <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_fs     <= 1'b0;
      r_ls     <= 1'b0;
    end else if (bus.CE) begin
      r_hphase <= w_hphase_nxt;
      r_hcnt   <= w_hcnt_nxt;
      r_run    <= 1'b1;
      r_hsync  <= w_hsync;
      r_vsync  <= w_vsync;
      r_de     <= w_de;
      r_x      <= r_hn;
      r_y      <= r_vn;
      r_fs     <= w_fs;
      r_ls     <= w_ls;
      if (r_hn == c_H_LAST) begin
        r_hn <= '0;
        r_vn <= (r_vn == c_V_LAST) ? 11'd0 : r_vn + 11'd1;
      end else begin
        r_hn <= r_hn + 11'd1;
      end
    end
  end

  assign bus.Hsync       = r_hsync;
  assign bus.Vsync       = r_vsync;
  assign bus.DE          = r_de;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.frame_start = r_fs;
  assign bus.line_start  = r_ls;

`ifdef VGA_TIMING_PATTERN_EN
  localparam int c_BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [2:0]  w_bar;
  logic [15:0] w_pattern;
  logic [15:0] r_pattern;

  // Bar index by threshold compare; leftover pixels past bar 7 stay black.
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (r_hn >= 11'(k * c_BAR_W)) w_bar = 3'(k);
    end
    w_pattern = 16'h0000;
    if (w_de) begin
      case (w_bar)
        3'd0: w_pattern = 16'hFFFF;
        3'd1: w_pattern = 16'hFFE0;
        3'd2: w_pattern = 16'h07FF;
        3'd3: w_pattern = 16'h07E0;
        3'd4: w_pattern = 16'hF81F;
        3'd5: w_pattern = 16'hF800;
        3'd6: w_pattern = 16'h001F;
        3'd7: w_pattern = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pattern <= 16'h0000;
    end else if (bus.CE) begin
      r_pattern <= w_pattern;
    end
  end

  assign bus.pattern = r_pattern;
`else
  assign bus.pattern = 16'h0000;
`endif

endmodule

`default_nettype wire
